input_device_port: RTL

- Device-side end of the basic computer's input-flag handshake.
- Accepts characters from an external input device, such as a keyboard model or testbench source, and buffers them in a small FIFO.
- Presents one character at a time on INPR with FGI raised.
- Clears FGI when the computer acknowledges with INP, then offers the next buffered character.
- Sits beside the BC_I-style top; its FGI output drives the computer's FGI input.

---
 rtl/io_pkg.sv | 20 ++
 rtl/io_fifo.sv | 81 ++++++++
 rtl/input_device_port.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// io_pkg: shared FSM state type, default sizing and width helpers for the
// input device port and its FIFO.
package io_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_GAP_CYC = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } io_state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO with registered full/empty flags. Pointers wrap
// modulo DEPTH; full and empty are told apart by the occupancy counter.
module io_fifo
  import io_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [DATA_W-1:0]       i_din,
  output logic [DATA_W-1:0]       o_dout,
  output logic [cnt_w(DEPTH)-1:0] o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic              r_full;
  logic              r_empty;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_push = i_push && !r_full;
  assign w_do_pop  = i_pop && !r_empty;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, counter and flags.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= ZERO_CNT;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == ZERO_CNT);
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/input_device_port.sv
// input_device_port: device side of the FGI/INPR input handshake, buffering
// characters in io_fifo. Optional odd-parity checking via PARITY_CHK_EN.
module input_device_port
  import io_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    dev_valid,
`ifdef PARITY_CHK_EN
  input  logic [DATA_W:0]         dev_data,
`else
  input  logic [DATA_W-1:0]       dev_data,
`endif
  output logic                    dev_ready,
  input  logic                    inp_ack,
  output logic [DATA_W-1:0]       INPR,
  output logic                    FGI,
  output logic                    overrun,
  output logic [cnt_w(DEPTH)-1:0] fifo_count
`ifdef PARITY_CHK_EN
  ,
  output logic                    par_err
`endif
);

  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);
  localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};

  io_state_e           r_state;
  io_state_e           w_state_nxt;
  logic [GW-1:0]       r_gap_cnt;
  logic [GW-1:0]       w_gap_nxt;
  logic                w_pop;
  logic                w_push;
  logic                w_par_ok;
  logic [DATA_W-1:0]   w_char;
  logic [DATA_W-1:0]   w_fifo_dout;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [DATA_W-1:0]   r_inpr;
  logic                r_fgi;
  logic                r_overrun;

`ifdef PARITY_CHK_EN
  logic                r_par_err;

  // Odd parity: the character plus its parity bit carry an odd number of ones.
  function automatic logic odd_par_ok(input logic [DATA_W:0] word);
    return ^word;
  endfunction

  assign w_char   = dev_data[DATA_W-1:0];
  assign w_par_ok = odd_par_ok(dev_data);
`else
  assign w_char   = dev_data;
  assign w_par_ok = 1'b1;
`endif

  // dev_ready comes from the registered full flag, so a pop in the same cycle
  // never opens room for a push into a full FIFO.
  assign w_push = dev_valid && !w_fifo_full && w_par_ok;

  io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_din     (w_char),
    .o_dout    (w_fifo_dout),
    .o_count   (fifo_count),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_state_nxt = PRESENT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PRESENT: begin
        if (inp_ack) begin
          w_state_nxt = GAP;
        end else begin
          w_state_nxt = PRESENT;
        end
      end
      GAP: begin
        if (r_gap_cnt != GAP_ZERO) begin
          w_state_nxt = GAP;
        end else if (!w_fifo_empty) begin
          w_state_nxt = PRESENT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: FIFO pop strobe and next gap count.
  always_comb begin
    w_pop     = 1'b0;
    w_gap_nxt = r_gap_cnt;
    case (r_state)
      IDLE: begin
        w_pop     = !w_fifo_empty;
        w_gap_nxt = GAP_ZERO;
      end
      PRESENT: begin
        if (inp_ack) begin
          w_gap_nxt = GAP_LOAD;
        end else begin
          w_gap_nxt = r_gap_cnt;
        end
      end
      GAP: begin
        if (r_gap_cnt == GAP_ZERO) begin
          w_pop     = !w_fifo_empty;
          w_gap_nxt = GAP_ZERO;
        end else begin
          w_pop     = 1'b0;
          w_gap_nxt = r_gap_cnt - GW'(1);
        end
      end
      default: begin
        w_pop     = 1'b0;
        w_gap_nxt = GAP_ZERO;
      end
    endcase
  end

  // Registered handshake outputs and gap counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gap_cnt <= GAP_ZERO;
      r_fgi     <= 1'b0;
      r_inpr    <= {DATA_W{1'b0}};
    end else begin
      r_gap_cnt <= w_gap_nxt;
      r_fgi     <= (w_state_nxt == PRESENT);
      if (w_pop) begin
        r_inpr <= w_fifo_dout;
      end
    end
  end

  // Sticky overrun: a character offered while the FIFO is full is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (dev_valid && w_fifo_full) begin
      r_overrun <= 1'b1;
    end
  end

`ifdef PARITY_CHK_EN
  // Sticky parity error on any offered character with bad parity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_par_err <= 1'b0;
    end else if (dev_valid && !w_par_ok) begin
      r_par_err <= 1'b1;
    end
  end

  assign par_err = r_par_err;
`endif

  assign dev_ready = !w_fifo_full;
  assign INPR      = r_inpr;
  assign FGI       = r_fgi;
  assign overrun   = r_overrun;

endmodule
